// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_renderer
//  Description : Single-sprite overlay for a VGA pixel stream. A host loads a
//                descriptor into a shadow slot; the shadow is promoted to the
//                active slot only at frame start so a frame never tears.
//                Two-stage pipeline: hit/border detect, then colour select.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_renderer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  pixelX,
   input  logic [9:0]  pixelY,
   input  logic        videoOn,
   input  logic        frameStart,
   input  logic        loadValid,
   output logic        loadReady,
   input  logic [9:0]  loadX,
   input  logic [9:0]  loadY,
   input  logic [23:0] loadColor,
   input  logic        loadEnable,
   input  logic [23:0] bgColor,
   output logic [7:0]  outRed,
   output logic [7:0]  outGreen,
   output logic [7:0]  outBlue,
   output logic        outActive
);

   // Extents are widened to 11 bits so X+W past column 1023 cannot wrap to 0.
   localparam logic [10:0] c_SPR_W  = 11'(SPRITE_W);
   localparam logic [10:0] c_SPR_H  = 11'(SPRITE_H);
   localparam logic [9:0]  c_H_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  c_V_LAST = 10'(V_ACTIVE - 1);
   localparam logic [23:0] c_WHITE  = 24'hFFFFFF;

   // Shadow descriptor, waiting for the next frame start
   logic        r_pending;
   logic [9:0]  r_shX;
   logic [9:0]  r_shY;
   logic [23:0] r_shColor;
   logic        r_shEn;

   // Active descriptor, the one being drawn this frame
   logic [9:0]  r_actX;
   logic [9:0]  r_actY;
   logic [23:0] r_actColor;
   logic        r_actEn;

   // Stage 1 pipeline registers
   logic        r_s1Hit;
   logic        r_s1Video;
   logic        r_s1Border;
   logic [23:0] r_s1Bg;

   // Stage 2 (output) registers
   logic [23:0] r_outColor;
   logic        r_outActive;

   logic        w_accept;
   logic        w_hitX;
   logic        w_hitY;
   logic        w_hit;
   logic        w_border;

   assign loadReady = !r_pending;
   assign w_accept  = loadValid && !r_pending;

   // Descriptor handshake: capture to shadow, promote to active on frame start only
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= 1'b0;
         r_shX      <= '0;
         r_shY      <= '0;
         r_shColor  <= '0;
         r_shEn     <= 1'b0;
         r_actX     <= '0;
         r_actY     <= '0;
         r_actColor <= '0;
         r_actEn    <= 1'b0;
      end else if (frameStart) begin
         if (r_pending) begin
            r_actX     <= r_shX;
            r_actY     <= r_shY;
            r_actColor <= r_shColor;
            r_actEn    <= r_shEn;
            r_pending  <= 1'b0;
         end else if (w_accept) begin
            // Load coinciding with frame start bypasses the shadow entirely
            r_actX     <= loadX;
            r_actY     <= loadY;
            r_actColor <= loadColor;
            r_actEn    <= loadEnable;
         end
      end else if (w_accept) begin
         r_shX     <= loadX;
         r_shY     <= loadY;
         r_shColor <= loadColor;
         r_shEn    <= loadEnable;
         r_pending <= 1'b1;
      end
   end

   assign w_hitX = ({1'b0, pixelX} >= {1'b0, r_actX}) &&
                   ({1'b0, pixelX} <  ({1'b0, r_actX} + c_SPR_W));
   assign w_hitY = ({1'b0, pixelY} >= {1'b0, r_actY}) &&
                   ({1'b0, pixelY} <  ({1'b0, r_actY} + c_SPR_H));
   assign w_hit  = r_actEn && videoOn && w_hitX && w_hitY;

   assign w_border = (pixelX == 10'd0) || (pixelX == c_H_LAST) ||
                     (pixelY == 10'd0) || (pixelY == c_V_LAST);

   // Stage 1: register hit/border classification and the background sample
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Hit    <= 1'b0;
         r_s1Video  <= 1'b0;
         r_s1Border <= 1'b0;
         r_s1Bg     <= '0;
      end else begin
         r_s1Hit    <= w_hit;
         r_s1Video  <= videoOn;
         r_s1Border <= w_border;
         r_s1Bg     <= bgColor;
      end
   end

   // Stage 2: colour priority blank > sprite > border > background
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outColor  <= '0;
         r_outActive <= 1'b0;
      end else begin
         r_outActive <= r_s1Video;
         if (!r_s1Video) begin
            r_outColor <= '0;
         end else if (r_s1Hit) begin
            r_outColor <= r_actColor;
         end else if (r_s1Border) begin
            r_outColor <= c_WHITE;
         end else begin
            r_outColor <= r_s1Bg;
         end
      end
   end

   assign outRed    = r_outColor[23:16];
   assign outGreen  = r_outColor[15:8];
   assign outBlue   = r_outColor[7:0];
   assign outActive = r_outActive;

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_renderer
//  Description : Self-checking bench for sprite_renderer. A descriptor-level
//                model predicts each pixel from screen geometry; directed
//                scenarios add hand-computed literal expectations, followed by
//                a randomized pixel/load/frame-start stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_renderer;

   localparam int HA = 640;
   localparam int VA = 480;
   localparam int SW = 16;
   localparam int SH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  pixelX = '0;
   logic [9:0]  pixelY = '0;
   logic        videoOn = 1'b0;
   logic        frameStart = 1'b0;
   logic        loadValid = 1'b0;
   logic        loadReady;
   logic [9:0]  loadX = '0;
   logic [9:0]  loadY = '0;
   logic [23:0] loadColor = '0;
   logic        loadEnable = 1'b0;
   logic [23:0] bgColor = '0;
   logic [7:0]  outRed;
   logic [7:0]  outGreen;
   logic [7:0]  outBlue;
   logic        outActive;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;

   // Descriptor-level model state
   int          mShX, mShY, mAX, mAY;
   logic [23:0] mShCol, mACol;
   bit          mShEn, mAEn, mPend;
   logic [24:0] exp1, exp2;

   sprite_renderer #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .SPRITE_W(SW), .SPRITE_H(SH)
   ) dut (
      .clk(clk), .rst(rst),
      .pixelX(pixelX), .pixelY(pixelY), .videoOn(videoOn),
      .frameStart(frameStart),
      .loadValid(loadValid), .loadReady(loadReady),
      .loadX(loadX), .loadY(loadY), .loadColor(loadColor), .loadEnable(loadEnable),
      .bgColor(bgColor),
      .outRed(outRed), .outGreen(outGreen), .outBlue(outBlue), .outActive(outActive)
   );

   always #5 clk = ~clk;

   // What the screen shows at (x,y) given the currently drawn sprite: {colour, active}
   function automatic logic [24:0] screen_pixel(int x, int y, bit von, logic [23:0] bg);
      if (!von) return 25'd0;
      if (mAEn && x >= mAX && x < mAX + SW && y >= mAY && y < mAY + SH) return {mACol, 1'b1};
      if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return {24'hFFFFFF, 1'b1};
      return {bg, 1'b1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_out(input string name, input logic [23:0] col, input bit act);
      check(name, {7'b0, outRed, outGreen, outBlue, outActive}, {7'b0, col, act});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present a pixel and wait the two-cycle latency
   task automatic pix(input int x, input int y, input bit von);
      pixelX  = 10'(x);
      pixelY  = 10'(y);
      videoOn = von;
      tick();
      tick();
   endtask

   task automatic load(input int x, input int y, input logic [23:0] c, input bit en);
      loadValid  = 1'b1;
      loadX      = 10'(x);
      loadY      = 10'(y);
      loadColor  = c;
      loadEnable = en;
      tick();
      loadValid  = 1'b0;
   endtask

   task automatic fstart();
      videoOn    = 1'b0;
      frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
   endtask

   // Model advance at each edge: pipeline the predicted pixel, then apply descriptor events
   always @(posedge clk) begin
      bit acc;
      if (rst) begin
         mShX = 0; mShY = 0; mShCol = '0; mShEn = 0;
         mAX = 0;  mAY = 0;  mACol = '0;  mAEn = 0;
         mPend = 0;
         exp1 = '0; exp2 = '0;
      end else begin
         exp2 = exp1;
         exp1 = screen_pixel(int'(pixelX), int'(pixelY), videoOn, bgColor);
         acc  = loadValid && !mPend;
         if (frameStart && mPend) begin
            mAX = mShX; mAY = mShY; mACol = mShCol; mAEn = mShEn; mPend = 0;
         end else if (frameStart && acc) begin
            mAX = int'(loadX); mAY = int'(loadY); mACol = loadColor; mAEn = loadEnable;
         end else if (acc) begin
            mShX = int'(loadX); mShY = int'(loadY); mShCol = loadColor; mShEn = loadEnable;
            mPend = 1;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (started) begin
         check("pixel_stream", {7'b0, outRed, outGreen, outBlue, outActive}, {7'b0, exp2});
         check("load_ready", {31'b0, loadReady}, {31'b0, !mPend});
      end
   end

   initial begin
      int x, y;
      repeat (3) tick();
      expect_out("reset_outputs", 24'h000000, 1'b0);
      rst = 1'b0;
      started = 1'b1;
      tick();
      check("ready_after_reset", {31'b0, loadReady}, 32'd1);

      // Plain background pixel
      bgColor = 24'h102030;
      pix(100, 100, 1);
      expect_out("bg_basic", 24'h102030, 1'b1);

      // Load then promote at frame start
      load(100, 50, 24'hFF0000, 1);
      check("ready_low_pending", {31'b0, loadReady}, 32'd0);
      pix(5, 5, 1);
      check("ready_low_midframe", {31'b0, loadReady}, 32'd0);
      fstart();
      check("ready_after_fs", {31'b0, loadReady}, 32'd1);
      pix(100, 50, 1);  expect_out("sprite_tl", 24'hFF0000, 1'b1);
      pix(115, 65, 1);  expect_out("sprite_br", 24'hFF0000, 1'b1);
      pix(116, 65, 1);  expect_out("right_of_sprite", 24'h102030, 1'b1);
      pix(99, 50, 1);   expect_out("left_of_sprite", 24'h102030, 1'b1);

      // Pending load without frame start keeps the old sprite; second load refused
      load(300, 200, 24'h00FF00, 1);
      pix(100, 50, 1);  expect_out("old_sprite_kept", 24'hFF0000, 1'b1);
      pix(300, 200, 1); expect_out("new_not_yet", 24'h102030, 1'b1);
      load(400, 300, 24'h0000FF, 1);
      check("ready_low_second", {31'b0, loadReady}, 32'd0);
      fstart();
      pix(300, 200, 1); expect_out("pending_promoted", 24'h00FF00, 1'b1);
      pix(400, 300, 1); expect_out("second_not_captured", 24'h102030, 1'b1);
      pix(100, 50, 1);  expect_out("old_sprite_gone", 24'h102030, 1'b1);

      // Clipping at the bottom-right corner
      load(630, 470, 24'hFF0000, 1);
      fstart();
      pix(630, 470, 1); expect_out("clip_tl", 24'hFF0000, 1'b1);
      pix(639, 479, 1); expect_out("clip_corner_priority", 24'hFF0000, 1'b1);
      pix(0, 470, 1);   expect_out("no_wrap_row470", 24'hFFFFFF, 1'b1);
      pix(0, 479, 1);   expect_out("no_wrap_row479", 24'hFFFFFF, 1'b1);
      pix(639, 100, 1); expect_out("right_border", 24'hFFFFFF, 1'b1);

      // Load and frame start in the same cycle
      videoOn    = 1'b0;
      frameStart = 1'b1;
      load(10, 10, 24'h0000FF, 1);
      frameStart = 1'b0;
      check("ready_fs_load", {31'b0, loadReady}, 32'd1);
      pix(10, 10, 1);   expect_out("fs_load_drawn", 24'h0000FF, 1'b1);
      pix(630, 470, 1); expect_out("fs_load_replaced", 24'h102030, 1'b1);

      // Blanking over the sprite, then reset mid-line
      pix(12, 12, 0);   expect_out("blank_over_sprite", 24'h000000, 1'b0);
      pix(12, 12, 1);   expect_out("sprite_before_rst", 24'h0000FF, 1'b1);
      rst = 1'b1;
      tick();
      expect_out("rst_midline", 24'h000000, 1'b0);
      rst = 1'b0;

      // Pending descriptor discarded by reset
      load(50, 60, 24'hFFFF00, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ready_after_midrst", {31'b0, loadReady}, 32'd1);
      fstart();
      pix(50, 60, 1);   expect_out("discarded_pending", 24'h102030, 1'b1);

      // Randomized stream checked by the every-cycle comparator
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 999) == 0);
         frameStart = ($urandom_range(0, 99) == 0);
         loadValid  = ($urandom_range(0, 19) == 0);
         loadX      = ($urandom_range(0, 3) == 0) ? 10'(620 + $urandom_range(0, 25)) : 10'($urandom);
         loadY      = ($urandom_range(0, 3) == 0) ? 10'(460 + $urandom_range(0, 25)) : 10'($urandom_range(0, 479));
         loadColor  = 24'($urandom);
         loadEnable = ($urandom_range(0, 3) != 0);
         bgColor    = 24'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            x = (mAX + $urandom_range(0, 19) - 2) & 1023;
            y = (mAY + $urandom_range(0, 19) - 2) & 1023;
         end else begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
         end
         pixelX  = 10'(x);
         pixelY  = 10'(y);
         videoOn = (x < HA && y < VA && !frameStart) ? ($urandom_range(0, 7) != 0) : 1'b0;
         tick();
      end
      rst        = 1'b0;
      frameStart = 1'b0;
      loadValid  = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
